shift_arbiter16: RTL and testbench

SHIFT_ARBITER16 -- requirements
Module: shift_arbiter16

---
 rtl/shift_arbiter16_pkg.sv | 29 ++
 rtl/sll_shifter16.sv | 27 ++
 rtl/shift_arbiter16.sv | 144 ++++++++++++++
 tb/tb_shift_arbiter16.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/shift_arbiter16_pkg.sv
// -----------------------------------------------------------------------------
// shift_arbiter16_pkg
// Shared definitions for the two-requester shift arbiter:
//   - data and shift-amount widths
//   - FSM state encoding (IDLE / SHIFT / RESP)
//   - bit_reverse helper, used to turn a left shifter into a right shifter
//     when the SHIFT_ARB_SRL_EN build option is enabled
// -----------------------------------------------------------------------------
package shift_arbiter16_pkg;

    localparam int DATA_W  = 16;
    localparam int SHAMT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    function automatic logic [DATA_W-1:0] bit_reverse(input logic [DATA_W-1:0] value);
        logic [DATA_W-1:0] reversed;
        reversed = '0;
        for (int i = 0; i < DATA_W; i++) begin
            reversed[i] = value[DATA_W-1-i];
        end
        return reversed;
    endfunction

endpackage

// File: rtl/sll_shifter16.sv
// -----------------------------------------------------------------------------
// sll_shifter16
// Combinational 16-bit logical left barrel shifter (zero fill; bits moved
// past bit 15 are discarded). Four binary-weighted stages.
// Ports:
//   operand  in   16  value to shift
//   shamt    in    4  shift amount, 0-15
//   shifted  out  16  operand << shamt
// -----------------------------------------------------------------------------
module sll_shifter16
    import shift_arbiter16_pkg::*;
(
    input  logic [DATA_W-1:0]  operand,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [DATA_W-1:0]  shifted
);

    logic [DATA_W-1:0] stage1;
    logic [DATA_W-1:0] stage2;
    logic [DATA_W-1:0] stage4;

    assign stage1  = shamt[0] ? {operand[DATA_W-2:0], 1'b0}  : operand;
    assign stage2  = shamt[1] ? {stage1[DATA_W-3:0], 2'b00}  : stage1;
    assign stage4  = shamt[2] ? {stage2[DATA_W-5:0], 4'h0}   : stage2;
    assign shifted = shamt[3] ? {stage4[DATA_W-9:0], 8'h00}  : stage4;

endmodule

// File: rtl/shift_arbiter16.sv
// -----------------------------------------------------------------------------
// shift_arbiter16
// Two requesters share one 16-bit barrel shifter. A round-robin arbiter picks
// a winner in IDLE, its operand is latched, shifted in SHIFT, and the result
// is returned with a one-cycle ack during RESP.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting; on a request, latch winner's operand/shamt
//   ST_SHIFT | write result from shifter, raise ack for the winner
//   ST_RESP  | ack high this cycle; on exit clear ack, update last_id
//
// Ports:
//   clock         in   1   sole clock, rising edge
//   reset         in   1   asynchronous, active-high
//   req0/req1     in   1   requests, held until the matching ack
//   data0/data1   in  16   operands
//   shamt0/shamt1 in   4   shift amounts
//   dir0/dir1     in   1   1 = logical right shift (SHIFT_ARB_SRL_EN only)
//   ack0/ack1     out  1   one-cycle result-valid pulses
//   result        out 16   registered shift result
//   busy          out  1   high whenever the FSM is not in IDLE
//
// Build option: define SHIFT_ARB_SRL_EN to add dir0/dir1 and right shifts.
// -----------------------------------------------------------------------------
module shift_arbiter16
    import shift_arbiter16_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               req0,
    input  logic [DATA_W-1:0]  data0,
    input  logic [SHAMT_W-1:0] shamt0,
    input  logic               req1,
    input  logic [DATA_W-1:0]  data1,
    input  logic [SHAMT_W-1:0] shamt1,
`ifdef SHIFT_ARB_SRL_EN
    input  logic               dir0,
    input  logic               dir1,
`endif
    output logic               ack0,
    output logic               ack1,
    output logic [DATA_W-1:0]  result,
    output logic               busy
);

    state_t state_q;
    state_t state_d;

    logic [DATA_W-1:0]  operand_q;
    logic [SHAMT_W-1:0] shamt_q;
    logic               grant_id;
    logic               last_id;
    logic               any_req;
    logic               win_id;
    logic [DATA_W-1:0]  shifter_in;
    logic [DATA_W-1:0]  shifter_out;
    logic [DATA_W-1:0]  shift_res;

    assign any_req = req0 | req1;
    // On a tie the requester not served last wins; otherwise whoever asks.
    assign win_id  = (req0 && req1) ? ~last_id : req1;
    assign busy    = (state_q != ST_IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (any_req) state_d = ST_SHIFT;
            ST_SHIFT: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            operand_q <= '0;
            shamt_q   <= '0;
            grant_id  <= 1'b0;
            last_id   <= 1'b1;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            result    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        operand_q <= win_id ? data1  : data0;
                        shamt_q   <= win_id ? shamt1 : shamt0;
                        grant_id  <= win_id;
                    end
                end
                ST_SHIFT: begin
                    result <= shift_res;
                    ack0   <= ~grant_id;
                    ack1   <= grant_id;
                end
                ST_RESP: begin
                    ack0    <= 1'b0;
                    ack1    <= 1'b0;
                    last_id <= grant_id;
                end
                default: begin
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                end
            endcase
        end
    end

`ifdef SHIFT_ARB_SRL_EN
    logic dir_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dir_q <= 1'b0;
        end else if (state_q == ST_IDLE && any_req) begin
            dir_q <= win_id ? dir1 : dir0;
        end
    end

    // Right shift = reverse, shift left, reverse back; reuses the one shifter.
    assign shifter_in = dir_q ? bit_reverse(operand_q)   : operand_q;
    assign shift_res  = dir_q ? bit_reverse(shifter_out) : shifter_out;
`else
    assign shifter_in = operand_q;
    assign shift_res  = shifter_out;
`endif

    sll_shifter16 u_sll_shifter16 (
        .operand (shifter_in),
        .shamt   (shamt_q),
        .shifted (shifter_out)
    );

endmodule

// File: tb/tb_shift_arbiter16.sv
// -----------------------------------------------------------------------------
// tb_shift_arbiter16
// Directed self-checking bench for shift_arbiter16. Inputs change 1 ns after
// a rising edge; outputs are checked at the same point.
// -----------------------------------------------------------------------------
module tb_shift_arbiter16;

    logic        clock;
    logic        reset;
    logic        req0;
    logic [15:0] data0;
    logic [3:0]  shamt0;
    logic        req1;
    logic [15:0] data1;
    logic [3:0]  shamt1;
`ifdef SHIFT_ARB_SRL_EN
    logic        dir0;
    logic        dir1;
`endif
    logic        ack0;
    logic        ack1;
    logic [15:0] result;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    shift_arbiter16 dut (
        .clock  (clock),
        .reset  (reset),
        .req0   (req0),
        .data0  (data0),
        .shamt0 (shamt0),
        .req1   (req1),
        .data1  (data1),
        .shamt1 (shamt1),
`ifdef SHIFT_ARB_SRL_EN
        .dir0   (dir0),
        .dir1   (dir1),
`endif
        .ack0   (ack0),
        .ack1   (ack1),
        .result (result),
        .busy   (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Only one ack may ever be high.
    always @(negedge clock) begin
        if (!reset) check_eq("ack_exclusive", {15'd0, ack0 & ack1}, 16'h0000);
    end

    // Single requester, full operation from IDLE; returns to IDLE at the end.
    task automatic single_op(input bit sel, input logic [15:0] d, input logic [3:0] sh,
                             input logic [15:0] exp, input string tag);
        if (sel) begin req1 = 1'b1; data1 = d; shamt1 = sh; end
        else     begin req0 = 1'b1; data0 = d; shamt0 = sh; end
        tick();
        check_eq({tag, "_busy"}, {15'd0, busy}, 16'h0001);
        tick();
        check_eq({tag, "_ack0"}, {15'd0, ack0}, {15'd0, ~sel});
        check_eq({tag, "_ack1"}, {15'd0, ack1}, {15'd0, sel});
        check_eq({tag, "_result"}, result, exp);
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        check_eq({tag, "_done"}, {14'd0, ack1, ack0}, 16'h0000);
        check_eq({tag, "_idle"}, {15'd0, busy}, 16'h0000);
    endtask

    initial begin
        reset  = 1'b1;
        req0   = 1'b0; data0 = '0; shamt0 = '0;
        req1   = 1'b0; data1 = '0; shamt1 = '0;
`ifdef SHIFT_ARB_SRL_EN
        dir0   = 1'b0;
        dir1   = 1'b0;
`endif
        tick();
        tick();
        check_eq("rst_ack", {14'd0, ack1, ack0}, 16'h0000);
        check_eq("rst_result", result, 16'h0000);
        check_eq("rst_busy", {15'd0, busy}, 16'h0000);
        reset = 1'b0;
        tick();

        // req0 only; operand changed after latch must not affect result.
        req0 = 1'b1; data0 = 16'h0001; shamt0 = 4'd4;
        tick();
        check_eq("t1_busy", {15'd0, busy}, 16'h0001);
        check_eq("t1_noack_early", {14'd0, ack1, ack0}, 16'h0000);
        data0 = 16'hFFFF; shamt0 = 4'd0;
        tick();
        check_eq("t1_ack0", {15'd0, ack0}, 16'h0001);
        check_eq("t1_ack1", {15'd0, ack1}, 16'h0000);
        check_eq("t1_result", result, 16'h0010);
        req0 = 1'b0;
        tick();
        check_eq("t1_ack_clear", {15'd0, ack0}, 16'h0000);
        check_eq("t1_idle", {15'd0, busy}, 16'h0000);
        check_eq("t1_result_hold", result, 16'h0010);

        // Tie straight after reset: requester 0 first, then 1.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req0 = 1'b1; data0 = 16'h00FF; shamt0 = 4'd8;
        req1 = 1'b1; data1 = 16'h8001; shamt1 = 4'd1;
        tick();
        tick();
        check_eq("t2_first_ack0", {15'd0, ack0}, 16'h0001);
        check_eq("t2_first_ack1", {15'd0, ack1}, 16'h0000);
        check_eq("t2_first_result", result, 16'hFF00);
        req0 = 1'b0;
        tick();
        check_eq("t2_gap_idle", {15'd0, busy}, 16'h0000);
        tick();
        tick();
        check_eq("t2_second_ack1", {15'd0, ack1}, 16'h0001);
        check_eq("t2_second_ack0", {15'd0, ack0}, 16'h0000);
        check_eq("t2_second_result", result, 16'h0002);
        req1 = 1'b0;
        tick();

        // Both held for four operations: strict alternation, one idle cycle.
        req0 = 1'b1; data0 = 16'h0003; shamt0 = 4'd1;
        req1 = 1'b1; data1 = 16'h0005; shamt1 = 4'd2;
        for (int op = 0; op < 4; op++) begin
            check_eq($sformatf("t3_op%0d_idle", op), {15'd0, busy}, 16'h0000);
            tick();
            check_eq($sformatf("t3_op%0d_busy", op), {15'd0, busy}, 16'h0001);
            tick();
            check_eq($sformatf("t3_op%0d_acks", op), {14'd0, ack1, ack0},
                     (op % 2 == 0) ? 16'h0001 : 16'h0002);
            check_eq($sformatf("t3_op%0d_result", op), result,
                     (op % 2 == 0) ? 16'h0006 : 16'h0014);
            tick();
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        check_eq("t3_end_idle", {15'd0, busy}, 16'h0000);

        // Shift-amount boundaries.
        single_op(1'b0, 16'hABCD, 4'd0,  16'hABCD, "t4_sh0");
        single_op(1'b0, 16'hABCD, 4'd15, 16'h8000, "t4_sh15");
        single_op(1'b1, 16'h1234, 4'd4,  16'h2340, "t4_r1_sh4");

        // Reset during SHIFT aborts; held req1 served after release.
        req1 = 1'b1; data1 = 16'h0007; shamt1 = 4'd1;
        tick();
        check_eq("t5_in_shift", {15'd0, busy}, 16'h0001);
        reset = 1'b1;
        #1;
        check_eq("t5_rst_busy", {15'd0, busy}, 16'h0000);
        check_eq("t5_rst_result", result, 16'h0000);
        tick();
        check_eq("t5_rst_noack", {14'd0, ack1, ack0}, 16'h0000);
        reset = 1'b0;
        #1;
        check_eq("t5_release_result", result, 16'h0000);
        tick();
        check_eq("t5_rearb_busy", {15'd0, busy}, 16'h0001);
        tick();
        check_eq("t5_ack1", {14'd0, ack1, ack0}, 16'h0002);
        check_eq("t5_result", result, 16'h000E);
        req1 = 1'b0;
        tick();

`ifdef SHIFT_ARB_SRL_EN
        dir1 = 1'b1;
        single_op(1'b1, 16'h8000, 4'd15, 16'h0001, "t6_srl15");
        single_op(1'b1, 16'hF0F0, 4'd4,  16'h0F0F, "t6_srl4");
        dir1 = 1'b0;
        dir0 = 1'b0;
        single_op(1'b0, 16'h00F0, 4'd4,  16'h0F00, "t6_sll4");
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
